// File: rtl/b2b_board_readout.sv
// Drains one per-board output FIFO onto a valid/ready link with SOP/EOP framing,
// max-length policing, orphan dropping and saturating event/error counters.
module b2b_board_readout #(
    parameter int unsigned DATA_WIDTH      = 65,
    parameter int unsigned MAX_EVENT_WORDS = 1024,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                  b2b_clk,
    input  logic                  b2b_rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  event_count,
    output logic [CNT_WIDTH-1:0]  error_count
);

    localparam int unsigned PW = $clog2(MAX_EVENT_WORDS + 1);
    localparam int unsigned BW = DATA_WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DISCARD} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   cnt, cnt_next;
    logic            in_flight;
    logic [BW-1:0]   head, head_next;
    logic [BW-1:0]   skid, skid_next;
    logic            skid_valid, skid_valid_next, out_valid_next;
    logic            fwd, w_sop, w_eop, w_err, inc_event, inc_error;
    logic            accept;
    logic [1:0]      held;

    assign {out_data, out_sop, out_eop, out_err} = head;
    assign accept = out_valid & out_ready;

    // Words still occupying the buffer after this cycle's link handshake.
    assign held = 2'(out_valid & ~out_ready) + 2'(skid_valid);
    assign fifo_read_enable = b2b_rst_n & enable & ~fifo_empty & ((held + 2'(in_flight)) < 2'd2);

    always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
        if (!b2b_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Framing decision for the word arriving from the FIFO this cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fwd        = 1'b0;
        w_sop      = 1'b0;
        w_eop      = 1'b0;
        w_err      = 1'b0;
        inc_event  = 1'b0;
        inc_error  = 1'b0;
        if (in_flight) begin
            case (state)
                S_IDLE: begin
                    if (fifo_read_data[DATA_WIDTH-1]) begin
                        fwd        = 1'b1;
                        w_sop      = 1'b1;
                        cnt_next   = '0;
                        state_next = S_PAYLOAD;
                    end else begin
                        inc_error = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    fwd = 1'b1;
                    if (fifo_read_data[DATA_WIDTH-1]) begin
                        w_eop      = 1'b1;
                        inc_event  = 1'b1;
                        state_next = S_IDLE;
                    end else if (cnt == PW'(MAX_EVENT_WORDS - 1)) begin
                        w_eop      = 1'b1;
                        w_err      = 1'b1;
                        inc_error  = 1'b1;
                        state_next = S_DISCARD;
                    end else begin
                        cnt_next = cnt + PW'(1);
                    end
                end
                S_DISCARD: begin
                    if (fifo_read_data[DATA_WIDTH-1]) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Two-entry output buffer: head drives the link, skid catches a word while head stalls.
    always_comb begin
        head_next       = head;
        skid_next       = skid;
        skid_valid_next = skid_valid;
        out_valid_next  = out_valid;
        if (accept || !out_valid) begin
            if (skid_valid) begin
                head_next       = skid;
                out_valid_next  = 1'b1;
                skid_valid_next = fwd;
                if (fwd) begin
                    skid_next = {fifo_read_data, w_sop, w_eop, w_err};
                end
            end else begin
                out_valid_next = fwd;
                if (fwd) begin
                    head_next = {fifo_read_data, w_sop, w_eop, w_err};
                end
            end
        end else if (fwd) begin
            skid_next       = {fifo_read_data, w_sop, w_eop, w_err};
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
        if (!b2b_rst_n) begin
            in_flight  <= 1'b0;
            head       <= '0;
            skid       <= '0;
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            in_flight  <= fifo_read_enable;
            head       <= head_next;
            skid       <= skid_next;
            skid_valid <= skid_valid_next;
            out_valid  <= out_valid_next;
            busy       <= fifo_read_enable | out_valid_next | skid_valid_next |
                          (state_next != S_IDLE);
        end
    end

    // Saturating counters, bumped when the classifying word is captured.
    always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
        if (!b2b_rst_n) begin
            event_count <= '0;
            error_count <= '0;
        end else begin
            if (inc_event && (event_count != '1)) begin
                event_count <= event_count + CNT_WIDTH'(1);
            end
            if (inc_error && (error_count != '1)) begin
                error_count <= error_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_b2b_board_readout.sv
// Scoreboard bench for b2b_board_readout: FIFO model feeds the DUT, a monitor
// checks every link beat against the queue of expected beats.
module tb_b2b_board_readout;

    localparam int unsigned DW   = 65;
    localparam int unsigned MAXW = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned BW   = DW + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic [DW-1:0] fifo_read_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic          out_err;
    logic          busy;
    logic [CW-1:0] event_count;
    logic [CW-1:0] error_count;

    b2b_board_readout #(
        .DATA_WIDTH(DW), .MAX_EVENT_WORDS(MAXW), .CNT_WIDTH(CW)
    ) dut (
        .b2b_clk(clk), .b2b_rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_enable(fifo_read_enable), .fifo_read_data(fifo_read_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .busy(busy),
        .event_count(event_count), .error_count(error_count)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            ready_mode = 0;
    logic          rd_pending = 1'b0;
    logic [DW-1:0] rd_word = '0;
    int            rd_empty_viol = 0;
    int            first_pop_cyc = -1;
    int            first_valid_cyc = -1;
    int            beat_cycles[$];
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat = '0;

    // FIFO read data appears the cycle after the pop.
    always @(posedge clk) begin
        cyc++;
        if (rd_pending) fifo_read_data <= rd_word;
    end

    // Link driver, monitor and FIFO pop model, all away from the active edge.
    always @(negedge clk) begin
        logic [BW-1:0] got;
        logic [BW-1:0] want;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
        fifo_empty = (fifo_q.size() == 0);
        got = {out_data, out_sop, out_eop, out_err};
        if (prev_stall && rst_n) begin
            tests++;
            if (!out_valid || got != prev_beat) begin
                fails++;
                $display("FAIL hold_stable got=%h v=%0b required=%h", got, out_valid, prev_beat);
            end
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready && rst_n) begin
            beat_cycles.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat got=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    fails++;
                    $display("FAIL beat got=%h required=%h", got, want);
                end
            end
        end
        prev_stall = out_valid && !out_ready && rst_n;
        prev_beat  = got;
        #1;
        rd_pending = fifo_read_enable;
        if (fifo_read_enable) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (fifo_q.size() == 0) rd_empty_viol++;
            else rd_word = fifo_q.pop_front();
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic push(input logic meta, input logic [63:0] v);
        fifo_q.push_back({meta, v});
    endtask

    task automatic expect_beat(input logic meta, input logic [63:0] v,
                               input logic sop, input logic eop, input logic err);
        exp_q.push_back({meta, v, sop, eop, err});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, longint'(n >= 500), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_read_data = '0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_event_count", longint'(event_count), 0);
        check("rst_error_count", longint'(error_count), 0);
        check("rst_rd_en", longint'(fifo_read_enable), 0);

        // 1: preloaded clean event, streamed back-to-back
        do_reset();
        ready_mode = 0;
        push(1, 64'h100); push(0, 64'h1); push(0, 64'h2); push(0, 64'h3); push(1, 64'h1FF);
        expect_beat(1, 64'h100, 1, 0, 0);
        expect_beat(0, 64'h1, 0, 0, 0);
        expect_beat(0, 64'h2, 0, 0, 0);
        expect_beat(0, 64'h3, 0, 0, 0);
        expect_beat(1, 64'h1FF, 0, 1, 0);
        repeat (2) @(negedge clk);
        first_pop_cyc = -1;
        first_valid_cyc = -1;
        beat_cycles.delete();
        enable = 1'b1;
        drain("t1");
        check("t1_pop_to_valid", longint'(first_valid_cyc - first_pop_cyc), 2);
        check("t1_beats", longint'(beat_cycles.size()), 5);
        if (beat_cycles.size() == 5)
            check("t1_consecutive", longint'(beat_cycles[4] - beat_cycles[0]), 4);
        check("t1_event_count", longint'(event_count), 1);
        check("t1_error_count", longint'(error_count), 0);

        // 2: 20 words as four events, link ready toggling every cycle
        do_reset();
        ready_mode = 1;
        enable = 1'b1;
        for (int e = 0; e < 4; e++) begin
            push(1, 64'(16'hA000 + e));
            expect_beat(1, 64'(16'hA000 + e), 1, 0, 0);
            for (int d = 0; d < 3; d++) begin
                push(0, 64'(e * 16 + d));
                expect_beat(0, 64'(e * 16 + d), 0, 0, 0);
            end
            push(1, 64'(16'hF000 + e));
            expect_beat(1, 64'(16'hF000 + e), 0, 1, 0);
        end
        drain("t2");
        check("t2_event_count_sat", longint'(event_count), 3);
        check("t2_error_count", longint'(error_count), 0);
        check("t2_busy_idle", longint'(busy), 0);

        // 3: orphan data word ahead of a header-footer event
        do_reset();
        ready_mode = 0;
        enable = 1'b1;
        push(0, 64'hAA); push(1, 64'h200); push(1, 64'h2FF);
        expect_beat(1, 64'h200, 1, 0, 0);
        expect_beat(1, 64'h2FF, 0, 1, 0);
        drain("t3");
        check("t3_error_count", longint'(error_count), 1);
        check("t3_event_count", longint'(event_count), 1);

        // 4: over-long event truncated at the limit, following event clean
        do_reset();
        ready_mode = 0;
        enable = 1'b1;
        push(1, 64'h300);
        for (int d = 1; d <= 6; d++) push(0, 64'(d));
        push(1, 64'h3FF);
        push(1, 64'h400); push(0, 64'h7); push(1, 64'h4FF);
        expect_beat(1, 64'h300, 1, 0, 0);
        expect_beat(0, 64'h1, 0, 0, 0);
        expect_beat(0, 64'h2, 0, 0, 0);
        expect_beat(0, 64'h3, 0, 0, 0);
        expect_beat(0, 64'h4, 0, 1, 1);
        expect_beat(1, 64'h400, 1, 0, 0);
        expect_beat(0, 64'h7, 0, 0, 0);
        expect_beat(1, 64'h4FF, 0, 1, 0);
        drain("t4");
        check("t4_error_count", longint'(error_count), 1);
        check("t4_event_count", longint'(event_count), 1);

        // 5: reset while words are held in the output buffer
        do_reset();
        ready_mode = 2;
        enable = 1'b1;
        push(1, 64'h500); push(0, 64'h51); push(0, 64'h52); push(0, 64'h53);
        repeat (8) @(negedge clk);
        check("t5_held_valid", longint'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid_on_reset", longint'(out_valid), 0);
        check("t5_busy_on_reset", longint'(busy), 0);
        fifo_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        push(0, 64'h54); push(1, 64'h600); push(1, 64'h6FF);
        expect_beat(1, 64'h600, 1, 0, 0);
        expect_beat(1, 64'h6FF, 0, 1, 0);
        drain("t5");
        check("t5_error_count", longint'(error_count), 1);
        check("t5_event_count", longint'(event_count), 1);

        // 6: counters saturate at the narrow width
        do_reset();
        ready_mode = 0;
        enable = 1'b1;
        for (int e = 0; e < 5; e++) begin
            push(1, 64'(16'h7000 + e)); push(1, 64'(16'h7F00 + e)); push(0, 64'(16'hBB00 + e));
            expect_beat(1, 64'(16'h7000 + e), 1, 0, 0);
            expect_beat(1, 64'(16'h7F00 + e), 0, 1, 0);
        end
        drain("t6");
        check("t6_event_count_sat", longint'(event_count), 3);
        check("t6_error_count_sat", longint'(error_count), 3);

        check("never_read_empty", longint'(rd_empty_viol), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
